// File: rtl/morse_symbol_decoder_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse keypad decoding path: keypad values that
// carry meaning, special character codes and the decoder state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package morse_pkg;

   // Keypad values with a Morse meaning; every other value is ignored.
   localparam logic [3:0] KEY_DOT    = 4'h0;
   localparam logic [3:0] KEY_DASH   = 4'h1;
   localparam logic [3:0] KEY_COMMIT = 4'hE;
   localparam logic [3:0] KEY_CLEAR  = 4'hF;

   // Character codes: 0-25 letters, 26-35 digits, 63 for anything unknown.
   localparam logic [5:0] CHAR_INVALID    = 6'd63;
   localparam logic [5:0] CHAR_DIGIT_BASE = 6'd26;

   // One-hot decoder states.
   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_ACCUM  = 4'b0010,
      S_LOOKUP = 4'b0100,
      S_EMIT   = 4'b1000
   } state_t;

endpackage

// File: rtl/morse_symbol_decoder_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational Morse code table. The symbol buffer holds the newest symbol
// at bit 0 (dot=0, dash=1), so the first keyed symbol is bit len-1.
// Ports:
//   len  [2:0] in   number of valid symbols in bits (0-5)
//   bits [4:0] in   symbols, newest at bit 0, unused upper bits are 0
//   code [5:0] out  0-25 = A-Z, 26-35 = digits 0-9, 63 = not a valid code
// -----------------------------------------------------------------------------
module morse_lut
   import morse_pkg::*;
(
   input  logic [2:0] len,
   input  logic [4:0] bits,
   output logic [5:0] code
);

   always_comb begin
      code = CHAR_INVALID;
      case ({len, bits})
         {3'd2, 5'b00001}: code = 6'd0;   // A .-
         {3'd4, 5'b01000}: code = 6'd1;   // B -...
         {3'd4, 5'b01010}: code = 6'd2;   // C -.-.
         {3'd3, 5'b00100}: code = 6'd3;   // D -..
         {3'd1, 5'b00000}: code = 6'd4;   // E .
         {3'd4, 5'b00010}: code = 6'd5;   // F ..-.
         {3'd3, 5'b00110}: code = 6'd6;   // G --.
         {3'd4, 5'b00000}: code = 6'd7;   // H ....
         {3'd2, 5'b00000}: code = 6'd8;   // I ..
         {3'd4, 5'b00111}: code = 6'd9;   // J .---
         {3'd3, 5'b00101}: code = 6'd10;  // K -.-
         {3'd4, 5'b00100}: code = 6'd11;  // L .-..
         {3'd2, 5'b00011}: code = 6'd12;  // M --
         {3'd2, 5'b00010}: code = 6'd13;  // N -.
         {3'd3, 5'b00111}: code = 6'd14;  // O ---
         {3'd4, 5'b00110}: code = 6'd15;  // P .--.
         {3'd4, 5'b01101}: code = 6'd16;  // Q --.-
         {3'd3, 5'b00010}: code = 6'd17;  // R .-.
         {3'd3, 5'b00000}: code = 6'd18;  // S ...
         {3'd1, 5'b00001}: code = 6'd19;  // T -
         {3'd3, 5'b00001}: code = 6'd20;  // U ..-
         {3'd4, 5'b00001}: code = 6'd21;  // V ...-
         {3'd3, 5'b00011}: code = 6'd22;  // W .--
         {3'd4, 5'b01001}: code = 6'd23;  // X -..-
         {3'd4, 5'b01011}: code = 6'd24;  // Y -.--
         {3'd4, 5'b01100}: code = 6'd25;  // Z --..
         {3'd5, 5'b11111}: code = CHAR_DIGIT_BASE + 6'd0;
         {3'd5, 5'b01111}: code = CHAR_DIGIT_BASE + 6'd1;
         {3'd5, 5'b00111}: code = CHAR_DIGIT_BASE + 6'd2;
         {3'd5, 5'b00011}: code = CHAR_DIGIT_BASE + 6'd3;
         {3'd5, 5'b00001}: code = CHAR_DIGIT_BASE + 6'd4;
         {3'd5, 5'b00000}: code = CHAR_DIGIT_BASE + 6'd5;
         {3'd5, 5'b10000}: code = CHAR_DIGIT_BASE + 6'd6;
         {3'd5, 5'b11000}: code = CHAR_DIGIT_BASE + 6'd7;
         {3'd5, 5'b11100}: code = CHAR_DIGIT_BASE + 6'd8;
         {3'd5, 5'b11110}: code = CHAR_DIGIT_BASE + 6'd9;
         default:          code = CHAR_INVALID;
      endcase
   end

endmodule

// File: rtl/morse_symbol_decoder.sv
// -----------------------------------------------------------------------------
// morse_symbol_decoder
// Turns keypad releases into Morse symbols, buffers up to five of them and,
// on a commit key, emits the decoded character with a one-cycle valid pulse.
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   key_pressed_flag in   high while a keypad key is held (keypad clock domain)
//   keyboard_val     in   [3:0] last key value, stable after release
//   char_code        out  [5:0] decoded character, held until the next emit
//   char_valid       out  one-cycle pulse marking a new char_code
//   sym_count        out  [2:0] symbols currently buffered (0-5)
//   sym_bits         out  [4:0] buffered symbols, newest at bit 0
//   overflow         out  sticky: a sixth symbol was keyed into a full buffer
// -----------------------------------------------------------------------------
module morse_symbol_decoder
   import morse_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_SYMBOLS = 5
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_pressed_flag,
   input  logic [3:0] keyboard_val,
   output logic [5:0] char_code,
   output logic       char_valid,
   output logic [2:0] sym_count,
   output logic [4:0] sym_bits,
   output logic       overflow
);

   logic [SYNC_STAGES-1:0] flag_sync_q;
   logic [3:0]             val_sync_q [SYNC_STAGES];
   logic                   flag_prev_q;

   state_t     state_q, state_d;
   logic [2:0] sym_count_q, sym_count_d;
   logic [4:0] sym_bits_q, sym_bits_d;
   logic       overflow_q, overflow_d;
   logic [5:0] char_code_q, char_code_d;
   logic [5:0] lut_code;

   logic       flag_s, key_event, is_sym, sym_v;
   logic [3:0] key_val;

   // Synchroniser chains and release-edge history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_sync_q <= '0;
         flag_prev_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) val_sync_q[i] <= 4'h0;
      end else begin
         flag_sync_q   <= {flag_sync_q[SYNC_STAGES-2:0], key_pressed_flag};
         flag_prev_q   <= flag_sync_q[SYNC_STAGES-1];
         val_sync_q[0] <= keyboard_val;
         for (int i = 1; i < SYNC_STAGES; i++) val_sync_q[i] <= val_sync_q[i-1];
      end
   end

   assign flag_s    = flag_sync_q[SYNC_STAGES-1];
   assign key_val   = val_sync_q[SYNC_STAGES-1];
   // Act on release only; the value is stable by then.
   assign key_event = flag_prev_q & ~flag_s;
   assign is_sym    = key_event & ((key_val == KEY_DOT) | (key_val == KEY_DASH));
   assign sym_v     = (key_val == KEY_DASH);

   morse_lut u_lut (
      .len  (sym_count_q),
      .bits (sym_bits_q),
      .code (lut_code)
   );

   // Decoder state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sym_count_q <= 3'd0;
         sym_bits_q  <= 5'd0;
         overflow_q  <= 1'b0;
         char_code_q <= 6'd0;
      end else begin
         state_q     <= state_d;
         sym_count_q <= sym_count_d;
         sym_bits_q  <= sym_bits_d;
         overflow_q  <= overflow_d;
         char_code_q <= char_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sym_count_d = sym_count_q;
      sym_bits_d  = sym_bits_q;
      overflow_d  = overflow_q;
      char_code_d = char_code_q;
      case (state_q)
         S_IDLE: begin
            // Commit and clear on an empty buffer are deliberately no-ops.
            if (is_sym) begin
               sym_bits_d  = {sym_bits_q[3:0], sym_v};
               sym_count_d = 3'd1;
               state_d     = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (is_sym) begin
               if (sym_count_q < 3'(MAX_SYMBOLS)) begin
                  sym_bits_d  = {sym_bits_q[3:0], sym_v};
                  sym_count_d = sym_count_q + 3'd1;
               end else begin
                  overflow_d = 1'b1;
               end
            end else if (key_event && key_val == KEY_COMMIT) begin
               state_d = S_LOOKUP;
            end else if (key_event && key_val == KEY_CLEAR) begin
               sym_count_d = 3'd0;
               sym_bits_d  = 5'd0;
               overflow_d  = 1'b0;
               state_d     = S_IDLE;
            end
         end
         S_LOOKUP: begin
            char_code_d = overflow_q ? CHAR_INVALID : lut_code;
            state_d     = S_EMIT;
         end
         S_EMIT: begin
            sym_count_d = 3'd0;
            sym_bits_d  = 5'd0;
            overflow_d  = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign char_code  = char_code_q;
   assign char_valid = (state_q == S_EMIT);
   assign sym_count  = sym_count_q;
   assign sym_bits   = sym_bits_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
module tb_morse_symbol_decoder;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_pressed_flag = 1'b0;
   logic [3:0] keyboard_val = 4'h0;
   logic [5:0] char_code;
   logic       char_valid;
   logic [2:0] sym_count;
   logic [4:0] sym_bits;
   logic       overflow;

   morse_symbol_decoder #(.SYNC_STAGES(SYNC), .MAX_SYMBOLS(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .key_pressed_flag (key_pressed_flag),
      .keyboard_val     (keyboard_val),
      .char_code        (char_code),
      .char_valid       (char_valid),
      .sym_count        (sym_count),
      .sym_bits         (sym_bits),
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: the letter as a list of symbols (0 dot, 1 dash).
   int  sym_q[$];
   bit  ovf_m;
   int  exp_code_q[$];
   int  exp_cyc_q[$];

   string morse_tab [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-",
      ".....", "-....", "--...", "---..", "----."};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_code();
      string s;
      s = "";
      if (ovf_m) return 63;
      foreach (sym_q[i]) s = {s, (sym_q[i] != 0) ? "-" : "."};
      for (int i = 0; i < 36; i++) if (morse_tab[i] == s) return i;
      return 63;
   endfunction

   function automatic int model_bits();
      int b;
      b = 0;
      foreach (sym_q[i]) b = (b << 1) | sym_q[i];
      return b;
   endfunction

   // Press and release one key, update the model at the release, then check
   // the live buffer once everything has settled.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      keyboard_val     = k;
      key_pressed_flag = 1'b1;
      repeat (3) @(negedge clk);
      key_pressed_flag = 1'b0;
      if (k == 4'h0 || k == 4'h1) begin
         if (sym_q.size() < 5) sym_q.push_back(int'(k));
         else ovf_m = 1'b1;
      end else if (k == 4'hE) begin
         if (sym_q.size() > 0) begin
            exp_code_q.push_back(model_code());
            exp_cyc_q.push_back(cyc + SYNC + 2);
            sym_q.delete();
            ovf_m = 1'b0;
         end
      end else if (k == 4'hF) begin
         sym_q.delete();
         ovf_m = 1'b0;
      end
      repeat (8) @(negedge clk);
      chk("sym_count", int'(sym_count), sym_q.size());
      chk("sym_bits",  int'(sym_bits),  model_bits());
      chk("overflow",  int'(overflow),  int'(ovf_m));
   endtask

   // Monitor: every char_valid cycle must match the oldest expected character.
   always @(negedge clk) begin
      if (!rst && char_valid) begin
         total++;
         if (exp_code_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: got code %0d at cycle %0d, none expected",
                     char_code, cyc);
         end else begin
            int ec, et;
            ec = exp_code_q.pop_front();
            et = exp_cyc_q.pop_front();
            if (int'(char_code) != ec || cyc != et) begin
               bad++;
               $display("FAIL char: got code %0d at cycle %0d expected code %0d at cycle %0d",
                        char_code, cyc, ec, et);
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_code"},  int'(char_code),  0);
      chk({tag, "_valid"}, int'(char_valid), 0);
      chk({tag, "_count"}, int'(sym_count),  0);
      chk({tag, "_bits"},  int'(sym_bits),   0);
      chk({tag, "_ovf"},   int'(overflow),   0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] k;
      int r;
      ovf_m = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // A, then '5' and '0'
      press(4'h0); press(4'h1); press(4'hE);
      repeat (5) press(4'h0); press(4'hE);
      repeat (5) press(4'h1); press(4'hE);
      // overflow then invalid commit
      repeat (6) press(4'h0); press(4'hE);
      // clear in the middle -> 'E'
      press(4'h1); press(4'h1); press(4'hF); press(4'h0); press(4'hE);
      // ignored keys and empty commit
      press(4'hE); press(4'h7); press(4'h0); press(4'hA); press(4'h5);
      press(4'hF); press(4'hE);

      // reset mid-letter, then 'T'
      press(4'h0); press(4'h1);
      @(negedge clk); #3;
      rst = 1'b1;
      #1;
      check_zero("midreset");
      sym_q.delete();
      ovf_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      press(4'h1); press(4'hE);

      // random keys
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 11);
         if (r < 4)       k = 4'h0;
         else if (r < 7)  k = 4'h1;
         else if (r < 9)  k = 4'hE;
         else if (r < 10) k = 4'hF;
         else             k = 4'($urandom_range(2, 13));
         press(k);
      end
      press(4'hE);

      repeat (20) @(negedge clk);
      chk("pending_chars", exp_code_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/morse_symbol_decoder.md
Name: morse_symbol_decoder

Overview:
- Consumes the debounced matrix-keypad output (key_pressed_flag and keyboard_val) on key release.
- Accumulates up to 5 Morse symbols (dot/dash) into a letter buffer.
- On a commit key, decodes the buffer to a 6-bit character code and emits a one-cycle valid pulse to the display/text stage downstream.
- Also exposes the live symbol buffer so the display can echo partial input.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronising key_pressed_flag and keyboard_val into clk (the keypad logic runs on a divided clock); minimum 2.
- MAX_SYMBOLS, 5, symbol buffer depth; fixed at 5 for this design.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  reset; asynchronous, active-high
- key_pressed_flag  input  1  high while a keypad key is held
- keyboard_val  input  4  last decoded key value; held stable after release
- char_code  output  6  decoded character: 0-25 = A-Z, 26-35 = digits 0-9, 63 = invalid
- char_valid  output  1  one-cycle pulse; char_code is valid in that cycle
- sym_count  output  3  number of symbols currently buffered, 0-5
- sym_bits  output  5  buffered symbols, newest at bit 0; dot=0, dash=1; bits at and above sym_count are 0
- overflow  output  1  sticky; set when a 6th symbol is entered, cleared on commit, clear key or reset

Behaviour:
- Reset (async, rst=1): char_code=0, char_valid=0, sym_count=0, sym_bits=0, overflow=0, state=S_IDLE, synchroniser chains all 0. Reset mid-letter discards the buffer; no char_valid is produced.
- Input capture:
  - Both inputs pass through SYNC_STAGES flops.
  - A key event fires in cycle T, the first cycle where the synchronised flag is 0 and its previous value was 1 (release edge).
  - The synchronised keyboard_val is sampled in cycle T.
  - Press edges are ignored.
- Key map (from package):
  - 4'h0 = DOT
  - 4'h1 = DASH
  - 4'hE = COMMIT
  - 4'hF = CLEAR
  - All other values are ignored with no state change.
- States:
  - S_IDLE (sym_count=0):
    - DOT/DASH: sym_bits={sym_bits[3:0],s}, sym_count=1, go to S_ACCUM.
    - COMMIT: ignored, no pulse.
    - CLEAR: no-op.
  - S_ACCUM (1-5 symbols):
    - DOT/DASH with sym_count<5: shift in, sym_count+1.
    - DOT/DASH with sym_count=5: buffer unchanged, overflow<=1.
    - COMMIT: go to S_LOOKUP.
    - CLEAR: sym_count=0, sym_bits=0, overflow=0, go to S_IDLE.
  - S_LOOKUP (1 cycle):
    - Register char_code from the morse_lut output, or 63 if overflow=1.
    - Go to S_EMIT.
  - S_EMIT (1 cycle):
    - char_valid=1.
    - Clear sym_count, sym_bits and overflow.
    - Go to S_IDLE.
- Commit latency: COMMIT event in cycle T -> S_LOOKUP in T+1 -> char_valid high in T+2 only.
- char_code holds its value until the next emit.
- Key events arriving during S_LOOKUP/S_EMIT are dropped. This is harmless in practice: release edges are at least one key_clk period (~21 ms) apart.
- Lookup table:
  - Letters use International Morse; A=.- -> 0, …, Z=--.. -> 25.
  - Digits are 5-symbol codes; 0=----- -> 26, 1=.---- -> 27, …, 9=----. -> 35.
  - Any (len, bits) pair not in the table gives 63.
- Simultaneous events: an event in the same cycle as rst is lost. Only one event per cycle is possible, by construction.

Decomposition:
- Package morse_pkg:
  - Key constants KEY_DOT=4'h0, KEY_DASH=4'h1, KEY_COMMIT=4'hE, KEY_CLEAR=4'hF.
  - CHAR_INVALID=6'd63, CHAR_DIGIT_BASE=6'd26.
  - State encoding, one-hot over 4 states.
- Sub-module morse_lut: purely combinational, inputs len[2:0] and bits[4:0], output code[5:0]. Reused by later text/display stages.

Test Plan:
- Keys 0,1,E (dot, dash, commit) -> sym_count 1 then 2, sym_bits=5'b00001; char_code=0 ('A') with char_valid for exactly one cycle, 2 cycles after the commit release edge is detected; then sym_count=0.
- Keys 0×5 then E -> char_code=31 ('5'); keys 1×5 then E -> char_code=26 ('0').
- Keys 0×6 -> overflow=1 after the 6th release with sym_count still 5; then E -> char_code=63, char_valid pulse, overflow=0.
- Keys 1,1,F,0,E -> CLEAR empties the buffer; result is char_code=4 ('E').
- E with an empty buffer, and keys 7/A/5 at any time -> no char_valid, sym_count unchanged.
- Keys 0,1 then assert rst mid-letter -> all outputs 0 immediately (async); the next 1,E sequence gives char_code=19 ('T').
